// File: rtl/lsu_queue_pkg.sv
// lsu_queue_pkg: op-field layout, size codes, FSM states and data helpers for the LSU queue
package lsu_queue_pkg;
    localparam int OP_ST  = 3;
    localparam int OP_UNS = 2;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_ABORT} state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SZ_H && a[0]) || (size == SZ_W && a != 2'b00);
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [3:0] op);
        return op[1:0] == SZ_B ? {{24{!op[OP_UNS] & d[7]}}, d[7:0]} :
               op[1:0] == SZ_H ? {{16{!op[OP_UNS] & d[15]}}, d[15:0]} : d;
    endfunction

    function automatic logic [31:0] store_mask(input logic [31:0] d, input logic [1:0] size);
        return size == SZ_B ? {24'h0, d[7:0]} : size == SZ_H ? {16'h0, d[15:0]} : d;
    endfunction
endpackage

// File: rtl/lsu_req_fifo.sv
// lsu_req_fifo: circular request FIFO with flush, gated by the global enable
module lsu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         flush_in,
    input  logic         push_in,
    input  logic         pop_in,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty_out,
    output logic         full_out
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0] count;
    logic do_push, do_pop;

    assign empty_out = count == '0;
    assign full_out  = count == (PW+1)'(DEPTH);
    assign do_pop    = pop_in && !flush_in && !empty_out;
    assign do_push   = push_in && !flush_in && (!full_out || do_pop);
    assign dout      = mem[head];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_push) tail <= tail + 1'b1;
                if (do_pop) head <= head + 1'b1;
                count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && do_push) mem[tail] <= din;
    end
endmodule

// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store issue to memory with CDB broadcast, store completion and rollback
module lsu_queue
    import lsu_queue_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic [3:0]        req_op_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [DATA_W-1:0] req_data_in,
    input  logic [TAG_W-1:0]  req_tag_in,
    output logic              store_done_out,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [1:0]        mem_size_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_done_in,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              cdb_valid_out,
    output logic [TAG_W-1:0]  cdb_tag_out,
    output logic [DATA_W-1:0] cdb_data_out,
    output logic              cdb_err_out,
    input  logic              rollback_in
);
    localparam int EW = 4 + ADDR_W + DATA_W + TAG_W;

    state_t state, state_nx;
    logic [EW-1:0] head_ent;
    logic [3:0] head_op, iss_op;
    logic [ADDR_W-1:0] head_addr, iss_addr;
    logic [DATA_W-1:0] head_data, iss_data, cdb_data_nx;
    logic [TAG_W-1:0] head_tag, iss_tag, cdb_tag_nx;
    logic empty, full, pop, issue;
    logic cdb_valid_nx, cdb_err_nx, store_done_nx;

    lsu_req_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush_in  (rollback_in),
        .push_in   (req_valid_in && req_ready_out),
        .pop_in    (pop),
        .din       ({req_op_in, req_addr_in, req_data_in, req_tag_in}),
        .dout      (head_ent),
        .empty_out (empty),
        .full_out  (full)
    );

    assign {head_op, head_addr, head_data, head_tag} = head_ent;
    assign req_ready_out = !full;
    assign mem_req_out   = state != S_IDLE;
    assign mem_we_out    = iss_op[OP_ST];
    assign mem_size_out  = iss_op[1:0];
    assign mem_addr_out  = iss_addr;
    assign mem_data_out  = iss_data;

    always_comb begin
        state_nx      = state;
        pop           = 1'b0;
        issue         = 1'b0;
        cdb_valid_nx  = 1'b0;
        cdb_err_nx    = cdb_err_out;
        cdb_data_nx   = cdb_data_out;
        cdb_tag_nx    = cdb_tag_out;
        store_done_nx = 1'b0;
        case (state)
            S_IDLE: if (!empty && !rollback_in) begin
                pop = 1'b1;
                if (!misaligned(head_op[1:0], head_addr[1:0])) begin
                    issue    = 1'b1;
                    state_nx = S_MEM;
                end else if (head_op[OP_ST]) begin
                    store_done_nx = 1'b1;
                end else begin
                    cdb_valid_nx = 1'b1;
                    cdb_err_nx   = 1'b1;
                    cdb_data_nx  = '0;
                    cdb_tag_nx   = head_tag;
                end
            end
            S_MEM: if (mem_done_in) begin
                state_nx = S_IDLE;
                if (iss_op[OP_ST]) begin
                    store_done_nx = 1'b1;
                end else if (!rollback_in) begin
                    cdb_valid_nx = 1'b1;
                    cdb_err_nx   = 1'b0;
                    cdb_data_nx  = load_ext(mem_data_in, iss_op);
                    cdb_tag_nx   = iss_tag;
                end
            end else if (rollback_in && !iss_op[OP_ST]) begin
                state_nx = S_ABORT;
            end
            // the aborted load still owns the memory port until it finishes
            S_ABORT: if (mem_done_in) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= S_IDLE;
            iss_op         <= '0;
            iss_addr       <= '0;
            iss_data       <= '0;
            iss_tag        <= '0;
            cdb_valid_out  <= 1'b0;
            cdb_err_out    <= 1'b0;
            cdb_data_out   <= '0;
            cdb_tag_out    <= '0;
            store_done_out <= 1'b0;
        end else if (rdy_in) begin
            state          <= state_nx;
            cdb_valid_out  <= cdb_valid_nx;
            cdb_err_out    <= cdb_err_nx;
            cdb_data_out   <= cdb_data_nx;
            cdb_tag_out    <= cdb_tag_nx;
            store_done_out <= store_done_nx;
            if (issue) begin
                iss_op   <= head_op;
                iss_addr <= head_addr;
                iss_data <= store_mask(head_data, head_op[1:0]);
                iss_tag  <= head_tag;
            end
        end
    end
endmodule

// File: tb/tb_lsu_queue.sv
// tb_lsu_queue: directed stimulus with scoreboard queues checked by an independent monitor
module tb_lsu_queue;
    typedef struct {
        logic        is_cdb;
        logic [3:0]  tag;
        logic [31:0] data;
        logic        err;
        logic        from_mem;
    } exp_t;
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } mreq_t;

    logic clk_in = 0, rst_in = 0, rdy_in = 1, req_valid_in = 0, rollback_in = 0;
    logic [3:0] req_op_in = 0, req_tag_in = 0;
    logic [31:0] req_addr_in = 0, req_data_in = 0, mem_data_in = 0;
    logic mem_done_in = 0;
    logic req_ready_out, store_done_out, mem_req_out, mem_we_out, cdb_valid_out, cdb_err_out;
    logic [1:0] mem_size_out;
    logic [31:0] mem_addr_out, mem_data_out, cdb_data_out;
    logic [3:0] cdb_tag_out;

    exp_t exp_q[$];
    mreq_t mem_q[$];
    int n_checks = 0, n_err = 0;
    int mem_lat = 1, mem_wait = 0, low_run = 0, last_gap = 0;
    logic mem_stall = 0, done_q = 0, prev_req = 0;
    exp_t e;
    mreq_t m, cur;

    lsu_queue #(.ADDR_W(32), .DATA_W(32), .TAG_W(4), .DEPTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_op_in(req_op_in), .req_addr_in(req_addr_in),
        .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .store_done_out(store_done_out), .mem_req_out(mem_req_out),
        .mem_we_out(mem_we_out), .mem_size_out(mem_size_out),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .mem_done_in(mem_done_in), .mem_data_in(mem_data_in),
        .cdb_valid_out(cdb_valid_out), .cdb_tag_out(cdb_tag_out),
        .cdb_data_out(cdb_data_out), .cdb_err_out(cdb_err_out),
        .rollback_in(rollback_in)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) done_q <= mem_done_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_cdb(input logic [3:0] tag, input logic [31:0] data, input logic err, input logic fm);
        exp_q.push_back('{1'b1, tag, data, err, fm});
    endtask

    task automatic exp_st(input logic fm);
        exp_q.push_back('{1'b0, 4'd0, 32'd0, 1'b0, fm});
    endtask

    task automatic exp_mem(input logic we, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        mem_q.push_back('{we, size, addr, data});
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] tag);
        int t = 0;
        while (!req_ready_out && t < 100) begin
            @(negedge clk_in);
            t++;
        end
        check("push_ready_timeout", 32'(t < 100), 1);
        req_valid_in = 1;
        req_op_in = op;
        req_addr_in = addr;
        req_data_in = data;
        req_tag_in = tag;
        @(negedge clk_in);
        req_valid_in = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0 || mem_req_out) && t < 200) begin
            @(negedge clk_in);
            t++;
        end
        check("idle_timeout", 32'(t < 200), 1);
        exp_q.delete();
        mem_q.delete();
        repeat (2) @(negedge clk_in);
    endtask

    // memory controller model: completes each access mem_lat cycles after it appears
    initial forever begin
        @(negedge clk_in);
        mem_done_in = 0;
        if (mem_req_out && !mem_stall) begin
            if (mem_wait >= mem_lat) begin
                mem_done_in = 1;
                mem_wait = 0;
            end else mem_wait++;
        end else if (!mem_req_out) mem_wait = 0;
    end

    initial forever begin
        @(negedge clk_in);
        if (cdb_valid_out || store_done_out) begin
            check("cdb_store_exclusive", 32'(cdb_valid_out & store_done_out), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_result: cdb_valid=%b store_done=%b tag=%h", cdb_valid_out, store_done_out, cdb_tag_out);
            end else begin
                e = exp_q.pop_front();
                check("result_kind", 32'(cdb_valid_out), 32'(e.is_cdb));
                if (e.is_cdb) begin
                    check("cdb_tag", 32'(cdb_tag_out), 32'(e.tag));
                    check("cdb_data", cdb_data_out, e.data);
                    check("cdb_err", 32'(cdb_err_out), 32'(e.err));
                end
                if (e.from_mem) check("result_latency", 32'(done_q), 1);
            end
        end
        if (mem_req_out && !prev_req) begin
            last_gap = low_run;
            cur = '{mem_we_out, mem_size_out, mem_addr_out, mem_data_out};
            if (mem_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_mem_req: addr=%h we=%b", mem_addr_out, mem_we_out);
            end else begin
                m = mem_q.pop_front();
                check("mem_we", 32'(mem_we_out), 32'(m.we));
                check("mem_size", 32'(mem_size_out), 32'(m.size));
                check("mem_addr", mem_addr_out, m.addr);
                if (m.we) check("mem_data", mem_data_out, m.data);
            end
        end else if (mem_req_out) begin
            check("mem_stable", {mem_we_out, mem_size_out, mem_addr_out[28:0]} ^ {cur.we, cur.size, cur.addr[28:0]}, 0);
            check("mem_data_stable", mem_data_out, cur.data);
        end
        low_run = mem_req_out ? 0 : low_run + 1;
        prev_req = mem_req_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (2) @(negedge clk_in);
        check("rst_ready", 32'(req_ready_out), 1);
        check("rst_mem_req", 32'(mem_req_out), 0);
        check("rst_mem_we", 32'(mem_we_out), 0);
        check("rst_cdb_valid", 32'(cdb_valid_out), 0);
        check("rst_store_done", 32'(store_done_out), 0);
        check("rst_cdb_data", cdb_data_out, 0);
        rst_in = 1;
        @(negedge clk_in);

        mem_data_in = 32'h000000F0;
        exp_mem(0, 0, 32'h100, 0);
        exp_cdb(3, 32'hFFFFFFF0, 0, 1);
        push(4'b0000, 32'h100, 0, 3);
        wait_idle();

        mem_data_in = 32'h1234ABCD;
        exp_mem(0, 1, 32'h200, 0);
        exp_mem(0, 2, 32'h204, 0);
        exp_cdb(5, 32'h0000ABCD, 0, 1);
        exp_cdb(6, 32'h1234ABCD, 0, 1);
        push(4'b0101, 32'h200, 0, 5);
        push(4'b0010, 32'h204, 0, 6);
        wait_idle();
        check("issue_gap", 32'(last_gap), 1);

        exp_mem(1, 0, 32'h3, 32'h000000EF);
        exp_st(1);
        push(4'b1000, 32'h3, 32'hDEADBEEF, 2);
        wait_idle();

        exp_mem(1, 1, 32'h10, 32'h0000BEEF);
        exp_st(1);
        push(4'b1001, 32'h10, 32'hDEADBEEF, 2);
        wait_idle();

        mem_data_in = 32'h00008001;
        exp_mem(0, 1, 32'h22, 0);
        exp_cdb(4, 32'hFFFF8001, 0, 1);
        push(4'b0001, 32'h22, 0, 4);
        wait_idle();

        mem_data_in = 32'hFFFFFFF0;
        exp_mem(0, 0, 32'h7, 0);
        exp_cdb(1, 32'h000000F0, 0, 1);
        push(4'b0100, 32'h7, 0, 1);
        wait_idle();

        exp_cdb(7, 32'h0, 1, 0);
        exp_st(0);
        exp_cdb(9, 32'h0, 1, 0);
        push(4'b0010, 32'h102, 32'hFFFFFFFF, 7);
        push(4'b1001, 32'h5, 32'h12345678, 8);
        push(4'b0001, 32'h3, 0, 9);
        wait_idle();

        mem_stall = 1;
        mem_data_in = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            exp_mem(0, 2, 32'h10 + 32'(4 * i), 0);
            exp_cdb(4'(i + 1), 32'hCAFEF00D, 0, 1);
        end
        push(4'b0010, 32'h10, 0, 1);
        repeat (2) @(negedge clk_in);
        check("fill_inflight", 32'(mem_req_out), 1);
        for (int i = 1; i < 5; i++) push(4'b0010, 32'h10 + 32'(4 * i), 0, 4'(i + 1));
        check("ready_full", 32'(req_ready_out), 0);
        req_valid_in = 1;
        req_op_in = 4'b0010;
        req_addr_in = 32'h99C;
        req_tag_in = 4'd15;
        repeat (3) @(negedge clk_in);
        check("ready_still_full", 32'(req_ready_out), 0);
        req_valid_in = 0;
        mem_stall = 0;
        t = 0;
        while (!cdb_valid_out && t < 50) begin
            @(negedge clk_in);
            t++;
        end
        check("first_done_seen", 32'(t < 50), 1);
        check("ready_at_done", 32'(req_ready_out), 0);
        @(negedge clk_in);
        check("ready_after_pop", 32'(req_ready_out), 1);
        wait_idle();

        mem_stall = 1;
        mem_data_in = 32'h55555555;
        exp_mem(0, 2, 32'h40, 0);
        push(4'b0010, 32'h40, 0, 8);
        repeat (2) @(negedge clk_in);
        push(4'b0010, 32'h44, 0, 9);
        push(4'b0010, 32'h48, 0, 10);
        push(4'b0010, 32'h4C, 0, 11);
        rollback_in = 1;
        @(negedge clk_in);
        rollback_in = 0;
        repeat (3) @(negedge clk_in);
        check("abort_req_held", 32'(mem_req_out), 1);
        mem_stall = 0;
        t = 0;
        while (mem_req_out && t < 50) begin
            @(negedge clk_in);
            t++;
        end
        check("abort_done_seen", 32'(t < 50), 1);
        repeat (3) @(negedge clk_in);
        mem_data_in = 32'h00000077;
        exp_mem(0, 2, 32'h80, 0);
        exp_cdb(12, 32'h00000077, 0, 1);
        push(4'b0010, 32'h80, 0, 12);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
